// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states, the
// instruction size and the counter-width helper used by the top and its FIFO.
package instruction_fetch_pkg;

  localparam int          INSTR_BYTES      = 4;
  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } fetch_state_e;

  // Occupancy / in-flight counters must be able to hold the value DEPTH itself
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Bus bundle of the fetch unit: PMEM request/response, decoder handshake
// and the redirect input. master = fetch unit, slave = its environment.
interface instruction_fetch_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  pmem_req_valid;
  logic                  pmem_req_ready;
  logic [ADDR_WIDTH-1:0] pmem_req_addr;
  logic                  pmem_rsp_valid;
  logic [31:0]           pmem_rsp_data;
  logic                  instr_valid;
  logic                  instr_ready;
  logic [31:0]           instr;
  logic [ADDR_WIDTH-1:0] instr_pc;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_addr;

  modport master (
    output pmem_req_valid, pmem_req_addr, instr_valid, instr, instr_pc,
    input  pmem_req_ready, pmem_rsp_valid, pmem_rsp_data, instr_ready,
           redirect_valid, redirect_addr
  );

  modport slave (
    input  pmem_req_valid, pmem_req_addr, instr_valid, instr, instr_pc,
    output pmem_req_ready, pmem_rsp_valid, pmem_rsp_data, instr_ready,
           redirect_valid, redirect_addr
  );
endinterface

// File: rtl/instruction_fetch_fetch_buffer.sv
// fetch_buffer: DEPTH-entry synchronous FIFO with flush and occupancy output.
// Head entry is presented straight from storage, zeroed while empty.
module fetch_buffer
  import instruction_fetch_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [cnt_w(DEPTH)-1:0]  o_count,
  output logic                     o_valid,
  output logic [WIDTH-1:0]         o_data
);
  localparam int CW = cnt_w(DEPTH);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  // Accept a push when a slot is free or the head leaves in the same cycle
  always_comb begin
    w_pop  = i_pop && (r_count != '0);
    w_push = i_push && ((r_count != CW'(DEPTH)) || w_pop);
  end

  // Pointer and occupancy tracking; flush empties the FIFO outright
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Entry storage: data only, no reset needed
  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_count = r_count;
  assign o_valid = (r_count != '0);
  assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: owns the PC, issues in-order PMEM reads under a credit
// rule (buffered + in-flight never exceeds BUF_DEPTH), buffers returned words
// and hands them to the decoder. Redirects retarget the PC, empty the buffer
// and drop responses that were already in flight.
// Optional feature macro: IFETCH_MISALIGN_EN (adds misalign_err port).
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    BUF_DEPTH    = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(RESET_VECTOR_DEF)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  instruction_fetch_if.master    if_fetch
`ifdef IFETCH_MISALIGN_EN
  ,
  output logic                   misalign_err
`endif
);
  localparam int CW = cnt_w(BUF_DEPTH);

  fetch_state_e          r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [CW-1:0]         r_inflight, w_inflight_nxt;
  logic [CW-1:0]         r_drop_cnt, w_drop_nxt;
  logic [CW-1:0]         w_count;
  logic [CW:0]           w_occupancy;
  logic                  w_redirect, w_misalign, w_req_valid, w_req_fire;
  logic                  w_rsp, w_push, w_pop, w_buf_valid;
  logic [ADDR_WIDTH-1:0] w_redirect_pc, w_rsp_pc;
  logic [31+ADDR_WIDTH:0] w_head;

`ifdef IFETCH_MISALIGN_EN
  logic r_misalign;

  // Misaligned redirect target blocks fetching until the next redirect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_misalign <= 1'b0;
    else if (w_redirect) r_misalign <= |if_fetch.redirect_addr[1:0];
  end

  assign misalign_err = r_misalign;
  assign w_misalign   = r_misalign;
`else
  assign w_misalign   = 1'b0;
`endif

  // Request credit, handshakes and the PC of the oldest outstanding read
  always_comb begin
    w_redirect     = if_fetch.redirect_valid;
    w_occupancy    = {1'b0, w_count} + {1'b0, r_inflight};
    w_req_valid    = (r_state == ST_RUN) && (w_occupancy < (CW+1)'(BUF_DEPTH)) && !w_misalign;
    w_req_fire     = w_req_valid && if_fetch.pmem_req_ready;
    w_rsp          = if_fetch.pmem_rsp_valid;
    w_inflight_nxt = r_inflight + CW'(w_req_fire) - CW'(w_rsp);
    w_push         = w_rsp && (r_state == ST_RUN) && !w_redirect;
    w_pop          = w_buf_valid && if_fetch.instr_ready && !w_redirect;
    w_redirect_pc  = {if_fetch.redirect_addr[ADDR_WIDTH-1:2], 2'b00};
    // In RUN all outstanding reads are consecutive words ending just below pc
    w_rsp_pc       = r_pc - (ADDR_WIDTH'(r_inflight) << 2);
  end

  // Next-state logic: stale reads after a redirect are drained in FLUSH
  always_comb begin
    w_state_nxt = r_state;
    w_drop_nxt  = r_drop_cnt;
    case (r_state)
      ST_BOOT: w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (w_redirect) begin
          w_drop_nxt = w_inflight_nxt;
          if (w_inflight_nxt != '0) w_state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        w_drop_nxt = r_drop_cnt - CW'(w_rsp);
        if (w_drop_nxt == '0) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_BOOT;
    endcase
  end

  // Control registers: state, in-flight and drop counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_BOOT;
      r_inflight <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_inflight_nxt;
      r_drop_cnt <= w_drop_nxt;
    end
  end

  // Program counter: redirect wins over sequential advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_pc <= RESET_VECTOR;
    else if (w_redirect) r_pc <= w_redirect_pc;
    else if (w_req_fire) r_pc <= r_pc + ADDR_WIDTH'(INSTR_BYTES);
  end

  fetch_buffer #(
    .WIDTH (32 + ADDR_WIDTH),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (w_redirect),
    .i_push  (w_push),
    .i_data  ({if_fetch.pmem_rsp_data, w_rsp_pc}),
    .i_pop   (w_pop),
    .o_count (w_count),
    .o_valid (w_buf_valid),
    .o_data  (w_head)
  );

  assign if_fetch.pmem_req_valid = w_req_valid;
  assign if_fetch.pmem_req_addr  = {r_pc[ADDR_WIDTH-1:2], 2'b00};
  assign if_fetch.instr_valid    = w_buf_valid;
  assign if_fetch.instr          = w_head[31+ADDR_WIDTH:ADDR_WIDTH];
  assign if_fetch.instr_pc       = w_head[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a latency-1 PMEM model whose
// word at address a is {a[15:0]^16'hBEEF, a[15:0]}.
module tb_instruction_fetch;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instruction_fetch_if #(.ADDR_WIDTH(32)) bus ();
`ifdef IFETCH_MISALIGN_EN
  logic misalign_err;
`endif

  instruction_fetch #(
    .ADDR_WIDTH   (32),
    .BUF_DEPTH    (2),
    .RESET_VECTOR (32'h0000_0000)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .if_fetch     (bus)
`ifdef IFETCH_MISALIGN_EN
    ,
    .misalign_err (misalign_err)
`endif
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          fire_cnt;
  bit          rsp_en;
  logic [31:0] pend_q[$];
  logic [31:0] beat_pc_q[$];
  logic [31:0] beat_data_q[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  // One clock cycle: record handshakes, then drive next-cycle PMEM response
  task automatic step();
    logic [31:0] a;
    #1;
    if (bus.pmem_req_valid && bus.pmem_req_ready) begin
      pend_q.push_back(bus.pmem_req_addr);
      fire_cnt++;
    end
    if (bus.instr_valid && bus.instr_ready) begin
      beat_pc_q.push_back(bus.instr_pc);
      beat_data_q.push_back(bus.instr);
    end
    @(posedge clk);
    #1;
    bus.pmem_rsp_valid = 1'b0;
    bus.pmem_rsp_data  = '0;
    if (rsp_en && pend_q.size() > 0) begin
      a = pend_q.pop_front();
      bus.pmem_rsp_valid = 1'b1;
      bus.pmem_rsp_data  = mem_word(a);
    end
  endtask

  task automatic run_until_beats(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && beat_pc_q.size() < n; i++) step();
    chk(tag, beat_pc_q.size(), n);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.pmem_req_ready = 1'b1;
    bus.pmem_rsp_valid = 1'b0;
    bus.pmem_rsp_data  = '0;
    bus.instr_ready    = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_addr  = '0;
    pend_q.delete();
    beat_pc_q.delete();
    beat_data_q.delete();
    fire_cnt = 0;
    rsp_en   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic redirect_to(input logic [31:0] addr);
    bus.redirect_valid = 1'b1;
    bus.redirect_addr  = addr;
    step();
    bus.redirect_valid = 1'b0;
    bus.redirect_addr  = '0;
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_req_valid"},   32'(bus.pmem_req_valid), 32'd0);
    chk({pfx, "_req_addr"},    bus.pmem_req_addr,       32'h0);
    chk({pfx, "_instr_valid"}, 32'(bus.instr_valid),    32'd0);
    chk({pfx, "_instr"},       bus.instr,               32'h0);
    chk({pfx, "_instr_pc"},    bus.instr_pc,            32'h0);
`ifdef IFETCH_MISALIGN_EN
    chk({pfx, "_misalign"},    32'(misalign_err),       32'd0);
`endif
  endtask

  initial begin
    bit found;
    bus.pmem_req_ready = 1'b1;
    bus.pmem_rsp_valid = 1'b0;
    bus.pmem_rsp_data  = '0;
    bus.instr_ready    = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_addr  = '0;

    // Reset state and sequential fetch
    #12;
    chk_reset_outputs("rst");
    do_reset();
    chk("boot_noreq", 32'(bus.pmem_req_valid), 32'd0);
    step();
    chk("run_req_valid", 32'(bus.pmem_req_valid), 32'd1);
    chk("run_req_addr",  bus.pmem_req_addr, 32'h0);
    run_until_beats("seq_beats", 3, 30);
    chk("seq_pc0",   beat_pc_q[0],   32'h0000_0000);
    chk("seq_pc1",   beat_pc_q[1],   32'h0000_0004);
    chk("seq_pc2",   beat_pc_q[2],   32'h0000_0008);
    chk("seq_data0", beat_data_q[0], 32'hBEEF_0000);
    chk("seq_data1", beat_data_q[1], 32'hBEEB_0004);
    chk("seq_data2", beat_data_q[2], 32'hBEE7_0008);

    // Decoder stall: exactly BUF_DEPTH requests, stable head, no loss
    do_reset();
    bus.instr_ready = 1'b0;
    repeat (12) step();
    chk("stall_fires", 32'(fire_cnt), 32'd2);
    chk("stall_valid", 32'(bus.instr_valid), 32'd1);
    chk("stall_pc",    bus.instr_pc, 32'h0);
    step();
    chk("stall_pc_hold",   bus.instr_pc, 32'h0);
    chk("stall_data_hold", bus.instr,    32'hBEEF_0000);
    bus.instr_ready = 1'b1;
    run_until_beats("stall_beats", 4, 40);
    chk("stall_b0", beat_pc_q[0], 32'h0);
    chk("stall_b1", beat_pc_q[1], 32'h4);
    chk("stall_b2", beat_pc_q[2], 32'h8);
    chk("stall_b3", beat_pc_q[3], 32'hC);
    chk("stall_d3", beat_data_q[3], 32'hBEE3_000C);

    // Redirect with two reads outstanding: both dropped
    do_reset();
    rsp_en = 1'b0;
    for (int i = 0; i < 10 && fire_cnt < 2; i++) step();
    chk("flight_fires", 32'(fire_cnt), 32'd2);
    chk("flight_noreq", 32'(bus.pmem_req_valid), 32'd0);
    rsp_en = 1'b1;
    redirect_to(32'h0000_0100);
    chk("flush_valid", 32'(bus.instr_valid),    32'd0);
    chk("flush_noreq", 32'(bus.pmem_req_valid), 32'd0);
    run_until_beats("flush_beats", 1, 30);
    chk("flush_pc",   beat_pc_q[0],   32'h0000_0100);
    chk("flush_data", beat_data_q[0], 32'hBFEF_0100);

    // Redirect coinciding with decoder handshake and a response
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      found = bus.instr_valid && bus.pmem_rsp_valid;
    end
    chk("coinc_found", 32'(found), 32'd1);
    redirect_to(32'h0000_0100);
    beat_pc_q.delete();
    beat_data_q.delete();
    chk("coinc_empty",     32'(bus.instr_valid),    32'd0);
    chk("coinc_req_valid", 32'(bus.pmem_req_valid), 32'd1);
    chk("coinc_req_addr",  bus.pmem_req_addr,       32'h0000_0100);
    run_until_beats("coinc_beats", 1, 30);
    chk("coinc_pc", beat_pc_q[0], 32'h0000_0100);

    // Misaligned redirect target
    do_reset();
    repeat (4) step();
    redirect_to(32'h0000_0102);
`ifdef IFETCH_MISALIGN_EN
    chk("mis_err",   32'(misalign_err),       32'd1);
    chk("mis_noreq", 32'(bus.pmem_req_valid), 32'd0);
    chk("mis_valid", 32'(bus.instr_valid),    32'd0);
    repeat (5) step();
    chk("mis_noreq_hold", 32'(bus.pmem_req_valid), 32'd0);
    beat_pc_q.delete();
    beat_data_q.delete();
    redirect_to(32'h0000_0200);
    chk("mis_clear", 32'(misalign_err), 32'd0);
    run_until_beats("mis_beats", 1, 30);
    chk("mis_pc",   beat_pc_q[0],   32'h0000_0200);
    chk("mis_data", beat_data_q[0], 32'hBCEF_0200);
`else
    beat_pc_q.delete();
    beat_data_q.delete();
    run_until_beats("lowbits_beats", 1, 30);
    chk("lowbits_pc",   beat_pc_q[0],   32'h0000_0100);
    chk("lowbits_data", beat_data_q[0], 32'hBFEF_0100);
`endif

    // Asynchronous reset mid-stream, then restart from the reset vector
    do_reset();
    repeat (4) step();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async");
    do_reset();
    run_until_beats("restart_beats", 2, 30);
    chk("restart_pc0",   beat_pc_q[0],   32'h0);
    chk("restart_pc1",   beat_pc_q[1],   32'h4);
    chk("restart_data0", beat_data_q[0], 32'hBEEF_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1);
  end

endmodule
